hzdpu_mc: RTL and testbench

- Parametrised hazard/pipeline-control unit for the 5-stage MIPS core. Next generation of the combinational hazard unit.
- Keeps the existing pcop/flush/stall contract, and adds:
  - multi-cycle load-use bubbles;
  - a HI/LO multiply/divide busy interlock;
  - whole-pipeline freeze on data-memory wait;
  - a saturating stall-cycle counter.
- Sits beside the ID stage. Drives the PC mux select, pipeline-register flush/bubble controls and stall enables.

---
 rtl/hzdpu_mc.sv | 191 +++++++++++++++++++
 tb/tb_hzdpu_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hzdpu_mc.sv
// -----------------------------------------------------------------------------
// hzdpu_mc -- hazard / pipeline-control unit for the 5-stage MIPS core.
//
// Sits beside the ID stage and decides, each cycle, how the front end moves.
// It resolves control redirects (J/JAL in ID, taken branch/JR in EX),
// multi-cycle load-use bubbles, the HI/LO mult/div busy interlock, and
// whole-pipeline freeze on data-memory wait. It also keeps a saturating
// count of the cycles lost to stall or freeze.
//
// Control outputs are combinational from the internal counters and the
// current inputs, so the decision takes effect in the same cycle.
//
// Parameters:
//   LU_CYC  bubble cycles per load-use hazard (1..3)
//   MD_LAT  mult/div result latency in cycles after issue (1..255)
//   CNTW    width of stall_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ID_jnjr    in   J/JAL decoded in ID
//   EX_bjjr    in   taken branch or JR resolved in EX
//   hzdlu      in   load in EX whose rd is read by the ID instruction
//   md_start   in   mult/div issuing from EX this cycle
//   md_use     in   ID instruction reads HI/LO or is a mult/div
//   mem_wait   in   data memory not ready
//   pcop       out  PC select: 0 PC+4, 1 ID jump, 2 EX branch/JR, 3 hold
//   flush      out  [0] clear IF/ID, [1] clear ID/EX, [2] bubble into ID/EX
//   stall      out  hold PC and IF/ID
//   freeze     out  hold every pipeline register
//   md_busy    out  mult/div result still pending
//   stall_cnt  out  saturating count of cycles with stall or freeze high
// -----------------------------------------------------------------------------
module hzdpu_mc #(
  parameter int unsigned LU_CYC = 1,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_jnjr,
  input  logic            EX_bjjr,
  input  logic            hzdlu,
  input  logic            md_start,
  input  logic            md_use,
  input  logic            mem_wait,
  output logic [1:0]      pcop,
  output logic [2:0]      flush,
  output logic            stall,
  output logic            freeze,
  output logic            md_busy,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int unsigned LUW = 2;
  localparam int unsigned MDW = 8;

  // PC mux encodings
  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_JMP  = 2'd1;
  localparam logic [1:0] PC_BR   = 2'd2;
  localparam logic [1:0] PC_HOLD = 2'd3;

  // Flush encodings
  localparam logic [2:0] FL_NONE   = 3'b000;
  localparam logic [2:0] FL_IFID   = 3'b001;
  localparam logic [2:0] FL_WRONG  = 3'b011;
  localparam logic [2:0] FL_BUBBLE = 3'b100;

  // Which priority row governs the current cycle
  typedef enum logic [2:0] {
    ROW_FREEZE,
    ROW_REDIRECT,
    ROW_LOADUSE,
    ROW_MDLOCK,
    ROW_JUMP,
    ROW_NONE
  } row_e;

  logic [LUW-1:0]  lu_cnt_q, lu_cnt_d;
  logic [MDW-1:0]  md_cnt_q, md_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  row_e row_c;
  logic lu_active_c;
  logic md_lock_c;

  // Counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q    <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy     = (md_cnt_q != '0);
  assign lu_active_c = hzdlu || (lu_cnt_q != '0);
  assign md_lock_c   = md_use && md_busy;

  // Priority select: memory wait, then wrong-path redirect, then the two
  // interlocks, then the ID jump. A taken branch beats load-use because the
  // ID instruction being held is on the wrong path anyway.
  always_comb begin
    row_c = ROW_NONE;
    if (mem_wait) begin
      row_c = ROW_FREEZE;
    end else if (EX_bjjr) begin
      row_c = ROW_REDIRECT;
    end else if (lu_active_c) begin
      row_c = ROW_LOADUSE;
    end else if (md_lock_c) begin
      row_c = ROW_MDLOCK;
    end else if (ID_jnjr) begin
      row_c = ROW_JUMP;
    end
  end

  // Output decode for the selected row
  always_comb begin
    pcop   = PC_SEQ;
    flush  = FL_NONE;
    stall  = 1'b0;
    freeze = 1'b0;
    unique case (row_c)
      ROW_FREEZE: begin
        pcop   = PC_HOLD;
        stall  = 1'b1;
        freeze = 1'b1;
      end
      ROW_REDIRECT: begin
        pcop  = PC_BR;
        flush = FL_WRONG;
      end
      ROW_LOADUSE, ROW_MDLOCK: begin
        pcop  = PC_HOLD;
        flush = FL_BUBBLE;
        stall = 1'b1;
      end
      ROW_JUMP: begin
        pcop  = PC_JMP;
        flush = FL_IFID;
      end
      default: begin
        pcop  = PC_SEQ;
        flush = FL_NONE;
      end
    endcase
  end

  // Load-use bubble counter: holds the extra bubbles still owed after the
  // first stall cycle, frozen while memory waits, dropped on a redirect.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (!mem_wait) begin
      if (EX_bjjr) begin
        lu_cnt_d = '0;
      end else if (hzdlu && (lu_cnt_q == '0)) begin
        lu_cnt_d = LUW'(LU_CYC - 1);
      end else if (lu_cnt_q != '0) begin
        lu_cnt_d = lu_cnt_q - LUW'(1);
      end
    end
  end

  // Mult/div latency counter: the unit keeps running through a freeze, but
  // an issue from EX is only real when EX actually advances.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start && !freeze) begin
      md_cnt_d = MDW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end
  end

  // Lost-cycle counter, saturating at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall || freeze) && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hzdpu_mc.sv
// -----------------------------------------------------------------------------
// tb_hzdpu_mc -- bench for hzdpu_mc. Two instances with different parameter
// sets share the same stimulus; a behavioural model tracks, per instance, how
// many load-use bubbles are still owed, how many mult/div cycles remain and
// how many cycles have been lost, and predicts the outputs from the priority
// rules. Directed scenarios add literal expectations on instance 0
// (LU_CYC=2, MD_LAT=4, CNTW=4), followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_hzdpu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ID_jnjr = 1'b0;
  logic EX_bjjr = 1'b0;
  logic hzdlu = 1'b0;
  logic md_start = 1'b0;
  logic md_use = 1'b0;
  logic mem_wait = 1'b0;

  logic [1:0] pcop0, pcop1;
  logic [2:0] flush0, flush1;
  logic       stall0, stall1, freeze0, freeze1, busy0, busy1;
  logic [3:0] sc0;
  logic [7:0] sc1;

  // Stimulus bit positions: {jnjr, bjjr, hzdlu, md_start, md_use, mem_wait}
  localparam logic [5:0] J  = 6'b100000;
  localparam logic [5:0] B  = 6'b010000;
  localparam logic [5:0] H  = 6'b001000;
  localparam logic [5:0] MS = 6'b000100;
  localparam logic [5:0] MU = 6'b000010;
  localparam logic [5:0] MW = 6'b000001;
  localparam logic [5:0] Z  = 6'b000000;

  hzdpu_mc #(.LU_CYC(2), .MD_LAT(4), .CNTW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .ID_jnjr(ID_jnjr), .EX_bjjr(EX_bjjr),
    .hzdlu(hzdlu), .md_start(md_start), .md_use(md_use), .mem_wait(mem_wait),
    .pcop(pcop0), .flush(flush0), .stall(stall0), .freeze(freeze0),
    .md_busy(busy0), .stall_cnt(sc0)
  );

  hzdpu_mc #(.LU_CYC(3), .MD_LAT(7), .CNTW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ID_jnjr(ID_jnjr), .EX_bjjr(EX_bjjr),
    .hzdlu(hzdlu), .md_start(md_start), .md_use(md_use), .mem_wait(mem_wait),
    .pcop(pcop1), .flush(flush1), .stall(stall1), .freeze(freeze1),
    .md_busy(busy1), .stall_cnt(sc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance
  int lu_rem [2];
  int md_rem [2];
  int lost   [2];

  function automatic int p_lu(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int p_md(input int k);
    return (k == 0) ? 4 : 7;
  endfunction

  function automatic int p_max(input int k);
    return (k == 0) ? 15 : 255;
  endfunction

  // Expected {pcop, flush, stall, freeze, md_busy} from the priority rules
  function automatic logic [7:0] model_out(input int k);
    logic [1:0] pc;
    logic [2:0] fl;
    logic st, fr, bz;
    bz = (md_rem[k] > 0);
    pc = 2'd0; fl = 3'b000; st = 1'b0; fr = 1'b0;
    if (mem_wait) begin
      pc = 2'd3; st = 1'b1; fr = 1'b1;
    end else if (EX_bjjr) begin
      pc = 2'd2; fl = 3'b011;
    end else if (hzdlu || lu_rem[k] > 0) begin
      pc = 2'd3; fl = 3'b100; st = 1'b1;
    end else if (md_use && bz) begin
      pc = 2'd3; fl = 3'b100; st = 1'b1;
    end else if (ID_jnjr) begin
      pc = 2'd1; fl = 3'b001;
    end
    return {pc, fl, st, fr, bz};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lu_rem[k] = 0; md_rem[k] = 0; lost[k] = 0;
    end
  endtask

  // Advance the model across one active clock edge
  task automatic model_edge();
    logic [7:0] o;
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      if (!mem_wait) begin
        if (EX_bjjr) lu_rem[k] = 0;
        else if (hzdlu && lu_rem[k] == 0) lu_rem[k] = p_lu(k) - 1;
        else if (lu_rem[k] > 0) lu_rem[k] = lu_rem[k] - 1;
      end
      if (!mem_wait && md_start) md_rem[k] = p_md(k);
      else if (md_rem[k] > 0) md_rem[k] = md_rem[k] - 1;
      if ((o[2] || o[1]) && lost[k] < p_max(k)) lost[k] = lost[k] + 1;
    end
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Compare both instances against the model
  task automatic compare_all();
    logic [7:0] e, a;
    int s;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      a = (k == 0) ? {pcop0, flush0, stall0, freeze0, busy0}
                   : {pcop1, flush1, stall1, freeze1, busy1};
      s = (k == 0) ? int'(sc0) : int'(sc1);
      chk("pcop",      k, int'(a[7:6]), int'(e[7:6]));
      chk("flush",     k, int'(a[5:3]), int'(e[5:3]));
      chk("stall",     k, int'(a[2]),   int'(e[2]));
      chk("freeze",    k, int'(a[1]),   int'(e[1]));
      chk("md_busy",   k, int'(a[0]),   int'(e[0]));
      chk("stall_cnt", k, s,            lost[k]);
    end
  endtask

  task automatic drive(input logic [5:0] v);
    ID_jnjr  = v[5];
    EX_bjjr  = v[4];
    hzdlu    = v[3];
    md_start = v[2];
    md_use   = v[1];
    mem_wait = v[0];
  endtask

  // One cycle: let the model see the edge, apply new inputs, then compare
  task automatic cyc(input logic [5:0] v);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    drive(v);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input bit clr);
    @(negedge clk);
    if (clr) drive(Z);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_stall_cnt", 0, int'(sc0), 0);
    chk("rst_md_busy",   0, int'(busy0), 0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] v;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset release, all inputs idle
    cyc(Z);
    chk("idle_pcop",  0, int'(pcop0), 0);
    chk("idle_flush", 0, int'(flush0), 0);
    chk("idle_stall", 0, int'(stall0), 0);
    chk("idle_cnt",   0, int'(sc0), 0);

    // Load-use: one hzdlu pulse gives exactly two stall cycles
    cyc(H);
    chk("lu_c0_stall", 0, int'(stall0), 1);
    chk("lu_c0_pcop",  0, int'(pcop0), 3);
    chk("lu_c0_flush", 0, int'(flush0), 4);
    cyc(Z);
    chk("lu_c1_stall", 0, int'(stall0), 1);
    chk("lu_c1_flush", 0, int'(flush0), 4);
    cyc(Z);
    chk("lu_end_stall", 0, int'(stall0), 0);
    chk("lu_end_pcop",  0, int'(pcop0), 0);
    chk("lu_end_cnt",   0, int'(sc0), 2);

    // Taken branch beats load-use
    do_reset(1'b1);
    cyc(H | B);
    chk("br_pcop",  0, int'(pcop0), 2);
    chk("br_flush", 0, int'(flush0), 3);
    chk("br_stall", 0, int'(stall0), 0);
    cyc(Z);
    chk("br_next_stall", 0, int'(stall0), 0);

    // Mult/div interlock: busy cycles 1..4, release in cycle 5
    do_reset(1'b1);
    cyc(MS);
    chk("md_c0_busy", 0, int'(busy0), 0);
    for (int c = 1; c <= 4; c++) begin
      cyc(MU);
      chk("md_busy_hi", 0, int'(busy0), 1);
      chk("md_stall_hi", 0, int'(stall0), 1);
    end
    cyc(MU);
    chk("md_c5_busy", 0, int'(busy0), 0);
    chk("md_c5_stall", 0, int'(stall0), 0);

    // Memory wait in the middle of a two-cycle load-use stall
    do_reset(1'b1);
    cyc(H);
    for (int c = 0; c < 3; c++) begin
      cyc(MW);
      chk("mw_freeze", 0, int'(freeze0), 1);
      chk("mw_flush",  0, int'(flush0), 0);
      chk("mw_pcop",   0, int'(pcop0), 3);
    end
    cyc(Z);
    chk("mw_lu_rest", 0, int'(stall0), 1);
    chk("mw_lu_freeze", 0, int'(freeze0), 0);
    cyc(Z);
    chk("mw_done_stall", 0, int'(stall0), 0);
    chk("mw_done_cnt",   0, int'(sc0), 5);

    // Saturation, then asynchronous reset in the middle of the stall
    do_reset(1'b1);
    repeat (21) cyc(H);
    chk("sat_cnt", 0, int'(sc0), 15);
    do_reset(1'b0);
    cyc(Z);

    // Freeze wins over branch; redirect follows once memory is ready
    do_reset(1'b1);
    cyc(MW | B);
    chk("mwb_freeze", 0, int'(freeze0), 1);
    chk("mwb_pcop",   0, int'(pcop0), 3);
    cyc(B);
    chk("mwb_br_pcop",  0, int'(pcop0), 2);
    chk("mwb_br_flush", 0, int'(flush0), 3);

    // Load-use wins over jump; jump re-presented after the stall
    cyc(H | J);
    chk("luj_pcop", 0, int'(pcop0), 3);
    cyc(J);
    chk("luj_hold", 0, int'(stall0), 1);
    cyc(J);
    chk("luj_jump_pcop",  0, int'(pcop0), 1);
    chk("luj_jump_flush", 0, int'(flush0), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 1);
      v = '0;
      v[5] = ($urandom_range(0, 99) < 15);
      v[4] = ($urandom_range(0, 99) < 10);
      v[3] = ($urandom_range(0, 99) < 15);
      v[2] = ($urandom_range(0, 99) < 15);
      v[1] = ($urandom_range(0, 99) < 40);
      v[0] = ($urandom_range(0, 99) < 10);
      cyc(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
